// File: rtl/wb_store_forwarder_pkg.sv
// wb_store_forwarder_pkg
// Shared types and default sizing for the writeback store-forwarding slice.
//   FWD_MAX_IDS      : in-flight instruction IDs (power of 2)
//   FWD_NUM_WB_PORTS : writeback retire ports snooped
//   id_t             : instruction ID
//   wb_retire_t      : one retire port bundled {valid, id, data}
//   fwd_state_t      : forwarding responder FSM state
package wb_store_forwarder_pkg;

    localparam int FWD_MAX_IDS      = 8;
    localparam int FWD_NUM_WB_PORTS = 3;
    localparam int FWD_ID_W         = $clog2(FWD_MAX_IDS);
    localparam int FWD_DATA_W       = 32;

    typedef logic [FWD_ID_W-1:0]   id_t;
    typedef logic [FWD_DATA_W-1:0] fwd_data_t;

    typedef struct packed {
        logic      valid;
        id_t       id;
        fwd_data_t data;
    } wb_retire_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fwd_state_t;

endpackage

// File: rtl/wb_store_forwarder_if.sv
// wb_store_forwarder_if
// Store-queue <-> writeback forwarding handshake.
//   waiting   : queue requests the result of id_needed
//   id_needed : requested producer ID, meaningful only with waiting
//   ack       : queue has consumed data; only legal while id_done=1
//   id_done   : data is valid and held until ack (or flush/reset)
//   data      : forwarded 32-bit result
// Handshake: waiting is a request strobe taken only when the responder is
// idle; once taken, id_done stays high with data stable until the cycle in
// which ack is seen, and drops the following cycle. A flush or reset
// abandons the request from any state.
// Modports: master = store queue, slave = forwarder.
interface wb_store_forwarder_if
    import wb_store_forwarder_pkg::*;
#(
    parameter int ID_W = FWD_ID_W
);
    logic            waiting;
    logic [ID_W-1:0] id_needed;
    logic            ack;
    logic            id_done;
    logic [31:0]     data;

    modport master (
        output waiting,
        output id_needed,
        output ack,
        input  id_done,
        input  data
    );

    modport slave (
        input  waiting,
        input  id_needed,
        input  ack,
        output id_done,
        output data
    );
endinterface

// File: rtl/wb_store_forwarder_result_buffer.sv
// wb_result_buffer
// Per-ID result store snooping every writeback retire port.
//   clk, rst     : clock, synchronous active-high reset (clears retired only)
//   issue_valid  : an ID is being (re)allocated; clears its retired bit
//   issue_id     : ID being allocated
//   retire       : NUM_WB_PORTS retire bundles {valid, id, data}
//   rd_id        : ID looked up (asynchronous read)
//   rd_data      : stored result for rd_id
//   rd_retired   : rd_id has retired since its last allocation
module wb_result_buffer
    import wb_store_forwarder_pkg::*;
#(
    parameter int MAX_IDS      = FWD_MAX_IDS,
    parameter int NUM_WB_PORTS = FWD_NUM_WB_PORTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  id_t                           issue_id,
    input  wb_retire_t [NUM_WB_PORTS-1:0] retire,
    input  id_t                           rd_id,
    output fwd_data_t                     rd_data,
    output logic                          rd_retired
);

    // Data array is deliberately not reset: an entry is only trusted when
    // its retired bit is set, and that vector is reset.
    fwd_data_t          mem [MAX_IDS];
    logic [MAX_IDS-1:0] retired_q;

    // Walking ports from highest to lowest index makes the lowest port's
    // write the last one scheduled, so it wins on a same-ID collision.
    always_ff @(posedge clk) begin
        for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
            if (retire[p].valid) begin
                mem[retire[p].id] <= retire[p].data;
            end
        end
    end

    // Clear first, set after: a set on the same ID in the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            if (issue_valid) begin
                retired_q[issue_id] <= 1'b0;
            end
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (retire[p].valid) begin
                    retired_q[retire[p].id] <= 1'b1;
                end
            end
        end
    end

    assign rd_data    = mem[rd_id];
    assign rd_retired = retired_q[rd_id];

    // Collision flags: both cases are excluded by ID allocation.
    logic issue_retire_clash;
    logic dup_retire;

    always_comb begin
        issue_retire_clash = 1'b0;
        dup_retire         = 1'b0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (issue_valid && retire[p].valid && (retire[p].id == issue_id)) begin
                issue_retire_clash = 1'b1;
            end
            for (int q = p + 1; q < NUM_WB_PORTS; q++) begin
                if (retire[p].valid && retire[q].valid && (retire[p].id == retire[q].id)) begin
                    dup_retire = 1'b1;
                end
            end
        end
    end

    a_no_issue_retire_clash: assert property (
        @(posedge clk) disable iff (rst) !issue_retire_clash
    );

    a_no_dup_retire: assert property (
        @(posedge clk) disable iff (rst) !dup_retire
    );

endmodule

// File: rtl/wb_store_forwarder.sv
// wb_store_forwarder
// Writeback-side responder of the store-forwarding handshake. Supplies the
// 32-bit result of the instruction named by id_needed, either from the
// per-ID result buffer (producer already retired) or straight off a retire
// port (producer retiring now or later), and holds id_done until ack.
//   clk, rst        : clock, synchronous active-high reset
//   gc_issue_flush  : abandons any outstanding request (buffer untouched)
//   issue_valid     : ID (re)allocation strobe
//   issue_id        : ID being allocated
//   retire_valid    : per-port retire strobe
//   retire_id       : per-port retiring ID
//   retire_data     : per-port result
//   fwd             : forwarding handshake (slave side)
//   dbg_state       : current FSM state
module wb_store_forwarder
    import wb_store_forwarder_pkg::*;
#(
    parameter int MAX_IDS      = FWD_MAX_IDS,
    parameter int NUM_WB_PORTS = FWD_NUM_WB_PORTS,
    localparam int ID_W        = $clog2(MAX_IDS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gc_issue_flush,
    input  logic                               issue_valid,
    input  logic [ID_W-1:0]                    issue_id,
    input  logic [NUM_WB_PORTS-1:0]            retire_valid,
    input  logic [NUM_WB_PORTS-1:0][ID_W-1:0]  retire_id,
    input  logic [NUM_WB_PORTS-1:0][31:0]      retire_data,
    wb_store_forwarder_if.slave                fwd,
    output fwd_state_t                         dbg_state
);

    wb_retire_t [NUM_WB_PORTS-1:0] retire;

    always_comb begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            retire[p].valid = retire_valid[p];
            retire[p].id    = retire_id[p];
            retire[p].data  = retire_data[p];
        end
    end

    fwd_state_t state_q;
    fwd_state_t state_n;
    id_t        needed_id_r;
    fwd_data_t  data_r;

    id_t        req_id;
    logic       live_hit;
    fwd_data_t  live_data;
    fwd_data_t  buf_data;
    logic       buf_hit;

    logic       capture;
    fwd_data_t  capture_data;
    logic       load_needed;

    wb_result_buffer #(
        .MAX_IDS      (MAX_IDS),
        .NUM_WB_PORTS (NUM_WB_PORTS)
    ) u_result_buffer (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_id    (issue_id),
        .retire      (retire),
        .rd_id       (req_id),
        .rd_data     (buf_data),
        .rd_retired  (buf_hit)
    );

    // The ID being matched is the live request while idle and the latched
    // request while waiting. Port scan runs high-to-low so the lowest
    // matching port is the one left in live_data.
    always_comb begin
        req_id    = (state_q == IDLE) ? fwd.id_needed : needed_id_r;
        live_hit  = 1'b0;
        live_data = '0;
        for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
            if (retire[p].valid && (retire[p].id == req_id)) begin
                live_hit  = 1'b1;
                live_data = retire[p].data;
            end
        end
    end

    always_comb begin
        state_n      = state_q;
        capture      = 1'b0;
        load_needed  = 1'b0;
        // A live retire beats the buffer, which may still hold an older
        // value for this ID until the write lands at the clock edge.
        capture_data = live_hit ? live_data : buf_data;

        case (state_q)
            IDLE: begin
                if (fwd.waiting) begin
                    if (live_hit || buf_hit) begin
                        capture = 1'b1;
                        state_n = DONE;
                    end else begin
                        load_needed = 1'b1;
                        state_n     = WAIT;
                    end
                end
            end
            WAIT: begin
                // The buffer cannot turn a miss into a hit without a retire
                // on this ID, so only the live ports are examined here.
                if (live_hit) begin
                    capture = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (fwd.ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (gc_issue_flush) begin
            state_n     = IDLE;
            capture     = 1'b0;
            load_needed = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            needed_id_r <= '0;
            data_r      <= '0;
        end else begin
            state_q <= state_n;
            if (load_needed) begin
                needed_id_r <= fwd.id_needed;
            end
            if (capture) begin
                data_r <= capture_data;
            end
        end
    end

    assign fwd.id_done = (state_q == DONE);
    assign fwd.data    = data_r;
    assign dbg_state   = state_q;

    // Queue-side protocol: ack only while data is held; a request repeated
    // while waiting must name the same ID; never ack and request together.
    a_ack_only_in_done: assert property (
        @(posedge clk) disable iff (rst) !(fwd.ack && (state_q != DONE))
    );

    a_wait_same_id: assert property (
        @(posedge clk) disable iff (rst)
        !((state_q == WAIT) && fwd.waiting && (fwd.id_needed != needed_id_r))
    );

    a_no_ack_with_waiting: assert property (
        @(posedge clk) disable iff (rst) !(fwd.ack && fwd.waiting)
    );

endmodule
